// File: rtl/flop_pkg.sv
// flop_pkg: shared constants and helpers for the flop_pipe retiming register.
package flop_pkg;

  localparam int unsigned FLOP_WIDTH_DEF = 4;
  localparam int unsigned FLOP_DEPTH_DEF = 2;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// flop_pipe_stage: one valid/data slot of the pipeline with a valid/ready
// handshake on each side. Optional synchronous flush under FLOP_PIPE_FLUSH_EN.
module flop_pipe_stage
  import flop_pkg::*;
#(
  parameter int unsigned      WIDTH     = FLOP_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FLOP_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             v;
  logic [WIDTH-1:0] d;

  // A slot can take a new item when it is empty or its item leaves this cycle.
  assign in_ready  = !v || out_ready;
  assign out_valid = v;
  assign out_data  = d;

  // Valid bit follows the upstream offer on each move; data loads only on an accepted item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
`ifdef FLOP_PIPE_FLUSH_EN
      if (flush) v <= 1'b0;
      else
`endif
      if (in_ready) begin
        v <= in_valid;
        if (in_valid) d <= in_data;
      end
    end
  end

endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage valid/ready pipeline register with bubble collapsing,
// asynchronous active-low reset and an occupancy count.
// Optional feature macro: FLOP_PIPE_FLUSH_EN adds a synchronous flush port.
module flop_pipe
  import flop_pkg::*;
#(
  parameter int unsigned      WIDTH     = FLOP_WIDTH_DEF,
  parameter int unsigned      DEPTH     = FLOP_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef FLOP_PIPE_FLUSH_EN
  input  logic                       flush,
`endif
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Ready ripples back from out_ready through per-stage signals so that each
  // link of the combinational chain is a distinct net.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             s_in_valid;
    logic             s_ready;
    logic             s_out_ready;
    logic [WIDTH-1:0] s_in_data;

    if (i == 0) begin : g_first
      assign s_in_valid = in_valid;
      assign s_in_data  = in_data;
    end else begin : g_next
      assign s_in_valid = v[i-1];
      assign s_in_data  = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign s_out_ready = out_ready;
    end else begin : g_mid
      assign s_out_ready = g_stage[i+1].s_ready;
    end

    flop_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef FLOP_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (s_in_valid),
      .in_ready  (s_ready),
      .in_data   (s_in_data),
      .out_valid (v[i]),
      .out_ready (s_out_ready),
      .out_data  (d[i])
    );
  end

`ifdef FLOP_PIPE_FLUSH_EN
  assign in_ready  = g_stage[0].s_ready && !flush;
  assign out_valid = v[DEPTH-1] && !flush;
`else
  assign in_ready  = g_stage[0].s_ready;
  assign out_valid = v[DEPTH-1];
`endif
  assign out_data = d[DEPTH-1];

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CW'(v[i]);
    end
  end

endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: directed and randomized checks of flop_pipe against a
// queue-of-items reference model.
module tb_flop_pipe;
  import flop_pkg::*;

  localparam int unsigned      W  = FLOP_WIDTH_DEF;
  localparam int unsigned      D  = FLOP_DEPTH_DEF;
  localparam int unsigned      CW = cnt_w(D);
  localparam logic [W-1:0]     RV = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
`ifdef FLOP_PIPE_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  flop_pipe #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL (RV)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FLOP_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count)
  );

  // Model: items in arrival order, each with its stage position (0..D-1).
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } item_t;
  item_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Oldest item may exit (if ordy) or advance; each younger item advances
  // only into a position the item ahead of it has vacated. Entry is possible
  // if position 0 ends up free.
  function automatic bit m_in_ready(input bit ordy);
    int lim;
    lim = ordy ? int'(D) + 1 : int'(D);
    foreach (q[k]) begin
      lim = (q[k].pos + 1 < lim) ? q[k].pos + 1 : q[k].pos;
    end
    return lim > 0;
  endfunction

  task automatic m_step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
    item_t nq[$];
    item_t it;
    int    lim;
    bit    acc;
    if (fl) begin
      q.delete();
      return;
    end
    acc = m_in_ready(ordy);
    lim = ordy ? int'(D) + 1 : int'(D);
    foreach (q[k]) begin
      it = q[k];
      if (it.pos + 1 < lim) it.pos = it.pos + 1;
      lim = it.pos;
      if (it.pos < int'(D)) nq.push_back(it);
    end
    if (iv && acc) begin
      it.d = id;
      it.pos = 0;
      nq.push_back(it);
    end
    q = nq;
  endtask

  task automatic check_outputs(input bit fl);
    bit exp_ov;
    exp_ov = !fl && q.size() > 0 && q[0].pos == int'(D) - 1;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("out_data", 32'(out_data), 32'(q[0].d));
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), fl ? 32'd0 : 32'(m_in_ready(out_ready)));
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
`ifdef FLOP_PIPE_FLUSH_EN
    flush = fl;
`endif
    #1;
    check_outputs(fl);
    m_step(iv, id, ordy, fl);
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(D) + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] stream [4];
    stream[0] = 4'b0000; stream[1] = 4'b1111; stream[2] = 4'b1010; stream[3] = 4'b0101;

    // Reset held low: everything at reset value.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'(RV));
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) step(1'b1, stream[i], 1'b1, 1'b0);
    drain();

    // Backpressure: fill, hold 0101 upstream, then release.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b1010, 1'b0, 1'b0);
    #1 check("bp_full_count", 32'(count), 32'(D));
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b1, 1'b0);
    drain();

    // Bubble collapse with out_ready low.
    step(1'b1, 4'b1010, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    #1;
    check("bub_count",     32'(count),     32'd2);
    check("bub_out_valid", 32'(out_valid), 32'd1);
    check("bub_out_data",  32'(out_data),  32'(4'b1010));

    // Asynchronous reset between edges while full.
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_count",     32'(count),     32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_data",  32'(out_data),  32'(RV));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

`ifdef FLOP_PIPE_FLUSH_EN
    // Flush with a pending upstream offer: nothing accepted, occupancy cleared.
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b1);
    #1 check("flush_count", 32'(count), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit fl;
      fl = 1'b0;
`ifdef FLOP_PIPE_FLUSH_EN
      fl = ($urandom_range(0, 19) == 0);
`endif
      step(bit'($urandom_range(0, 3) != 0), W'($urandom), bit'($urandom_range(0, 2) != 0), fl);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flop_pipe.md
# flop_pipe

Parametrised pipeline register: a chain of DEPTH data stages, each WIDTH bits wide, with a valid/ready handshake on both ends. It replaces the plain D flop used to retime datapaths. Unlike the plain flop it adds stall handling with bubble collapsing, asynchronous reset and an occupancy count. It sits between producer and consumer blocks wherever a datapath needs registered retiming without losing backpressure.

## Interface
- WIDTH, 4: data width in bits, must be ≥1.
- DEPTH, 2: number of register stages, must be ≥1.
- RESET_VAL, '0: reset value of every data stage, WIDTH bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream data is valid.
- in_ready  output  1  stage 0 can accept data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts data this cycle.
- out_data  output  WIDTH  last stage data.
- count  output  $clog2(DEPTH+1)  number of valid stages.
- flush  input  1  synchronous pipeline clear. Present only with FLOP_PIPE_FLUSH_EN.

## Operation
- Each stage i holds a valid bit v[i] and data d[i]. Stage DEPTH-1 drives out_valid and out_data.
- Stage i advances when stage i+1 is empty or stage i+1 advances. The last stage advances when out_ready is high.
- ready[i] = !v[i] || advance[i]. in_ready = ready[0], which is combinational from out_ready through the chain.
- Transfer in: in_valid && in_ready. Stage 0 loads in_data and sets v[0].
- Transfer out: out_valid && out_ready. v[DEPTH-1] clears unless stage DEPTH-2 moves into it in the same cycle.
- Bubble collapsing: a valid stage moves into an empty stage downstream even while out_ready is low, so gaps close.
- Data registers load only on an accepted move. Invalid stages keep stale data. out_data is meaningful only while out_valid is high.
- count = number of set v[i]. It is updated in the same cycle as the valid bits.
- Ordering: items leave in arrival order. No item is lost or duplicated.

## Timing
- Reset (rst_n low, any time): all v[i] = 0 and all d[i] = RESET_VAL immediately. So out_valid = 0, out_data = RESET_VAL, count = 0, in_ready = 1.
- Reset mid-operation drops all in-flight data. The first clk edge after rst_n deasserts operates normally.
- Latency with no stall: data accepted at edge N is presented at out_data after edge N+DEPTH-1. An item therefore exits DEPTH cycles after entering.
- Throughput: 1 item/cycle while out_ready is held high.
- Full (count == DEPTH) and out_ready low: in_ready = 0 and all stages hold.
- Full and out_ready high: every stage advances and in_ready = 1. Simultaneous in and out transfers leave count unchanged.
- Empty: out_valid = 0 and out_ready is ignored.
- DEPTH = 1: a single stage. in_ready = !v[0] || out_ready.

## Configuration
- FLOP_PIPE_FLUSH_EN defined: the flush port exists.
  - While flush is high, in_ready = 0 and out_valid = 0, so no transfer happens.
  - At the next edge all v[i] = 0 and count = 0.
  - Data registers are not cleared.
  - If rst_n and flush are both active, reset dominates.
- FLOP_PIPE_FLUSH_EN undefined: no flush port and no flush logic. Behaviour is otherwise identical.

## Structure
- Package flop_pkg holds:
  - the default width constant FLOP_WIDTH_DEF = 4;
  - the default depth constant FLOP_DEPTH_DEF = 2;
  - a count-width function cnt_w(depth) = $clog2(depth+1), shared with the bench.
- Sub-module flop_pipe_stage: one valid/data stage with async-reset registers, in_valid/in_ready and out_valid/out_ready. The top instantiates it DEPTH times in a generate loop and sums the valid bits for count.

## Test plan
- Reset: hold rst_n low, then release with no input -> out_valid = 0, out_data = 4'b0000 (RESET_VAL), count = 0, in_ready = 1.
- Streaming (WIDTH 4, DEPTH 2, out_ready = 1): drive 0000, 1111, 1010, 0101 on consecutive cycles -> the same sequence appears on out_data starting 2 cycles after the first input, with out_valid held high for 4 cycles.
- Backpressure: out_ready = 0 while driving 1111, 1010, 0101 -> count reaches 2, then in_ready = 0 and 0101 is held upstream. Raise out_ready -> outputs are 1111, 1010, 0101 in order with no loss.
- Bubble collapse: send 1010, one idle cycle, then 0101, with out_ready = 0 -> both items end up adjacent in stages 1 and 0 and count = 2.
- Async reset mid-stream: assert rst_n low between clock edges while count = 2 -> out_valid drops and count = 0 immediately, without waiting for a clock edge.
- Flush (FLOP_PIPE_FLUSH_EN): with count = 2, pulse flush for one cycle while in_valid = 1 with 1111 -> in_ready = 0 during the pulse, then count = 0 and 1111 is not accepted.
